// File: rtl/integral_image_gen.sv
// Streaming integral-image generator: raster-order pixels in, one inclusive integral
// word written per accepted pixel at address x + width*y.
module integral_image_gen #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned SUM_W     = 32,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned MAX_WIDTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SUM_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IdxW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StLast, StReject} state_e;

  state_e            state_q;
  logic [15:0]       width_q, height_q;
  logic [15:0]       x_q, y_q;
  logic [SUM_W-1:0]  row_sum_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SUM_W-1:0]  prev_row [MAX_WIDTH];

  logic              accept;
  logic              x_last, y_last;
  logic              dims_bad;
  logic [31:0]       area;
  logic [SUM_W-1:0]  row_sum_new;
  logic [SUM_W-1:0]  ii;

  always_comb begin
    accept      = pix_valid & pix_ready;
    x_last      = (x_q == width_q - 16'd1);
    y_last      = (y_q == height_q - 16'd1);
    row_sum_new = ((x_q == 16'd0) ? '0 : row_sum_q) + SUM_W'(pix_data);
    // Row 0 ignores the buffer, so stale contents from earlier frames never leak in.
    ii          = ((y_q == 16'd0) ? '0 : prev_row[x_q[IdxW-1:0]]) + row_sum_new;
    area        = 32'(width) * 32'(height);
    dims_bad    = (width == 16'd0) || (height == 16'd0) || (32'(width) > MAX_WIDTH) ||
                  ({1'b0, area} > (33'd1 << ADDR_W));
  end

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      prev_row[x_q[IdxW-1:0]] <= ii;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      width_q   <= '0;
      height_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      row_sum_q <= '0;
      addr_q    <= '0;
      pix_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            width_q  <= width;
            height_q <= height;
            if (dims_bad) begin
              state_q <= StReject;
              err     <= 1'b1;
              done    <= 1'b1;
            end else begin
              x_q       <= '0;
              y_q       <= '0;
              row_sum_q <= '0;
              addr_q    <= '0;
              state_q   <= StRun;
              pix_ready <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            wr_en     <= 1'b1;
            wr_addr   <= addr_q;
            wr_data   <= ii;
            addr_q    <= addr_q + 1'b1;
            row_sum_q <= row_sum_new;
            if (x_last) begin
              x_q <= '0;
              y_q <= y_q + 16'd1;
              if (y_last) begin
                state_q   <= StLast;
                pix_ready <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              x_q <= x_q + 16'd1;
            end
          end
        end
        StLast: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        StReject: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/integral_image_gen.md
# integral_image_gen

Front-end stage for each face-detection core: accepts one core tile's 8-bit grayscale pixels in raster order and produces the tile's inclusive integral image. The integral image is written as a row-major word stream with address `x + width*y`. This matches the `next_row = width` addressing the filter core uses for its four-corner box sums. The output feeds the per-core image memory that the filter core reads before filtering starts.

## Interface
Parameters:
- `PIX_W`, 8: pixel width.
- `SUM_W`, 32: integral word width.
- `ADDR_W`, 17: write address width; covers 100000 words.
- `MAX_WIDTH`, 1024: depth of the previous-row buffer.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-low.
- `start`, in, 1: begin a frame; sampled only in IDLE.
- `width`, in, 16: tile width in pixels; latched on accepted `start`.
- `height`, in, 16: tile height in pixels; latched on accepted `start`.
- `pix_valid`, in, 1: `pix_data` is valid.
- `pix_data`, in, PIX_W: pixel value, unsigned.
- `pix_ready`, out, 1: block can accept a pixel.
- `wr_en`, out, 1: write strobe to image memory.
- `wr_addr`, out, ADDR_W: write address.
- `wr_data`, out, SUM_W: integral value.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse at frame end.
- `err`, out, 1: one-cycle pulse when a frame is rejected.

## Operation
- Integral definition: ii(x,y) = sum of p(i,j) for i<=x, j<=y.
- Per accepted pixel:
  - `row_sum <= (x==0 ? 0 : row_sum) + p`.
  - `ii = (y==0 ? 0 : prev_row[x]) + row_sum_new`.
  - `prev_row[x] <= ii`.
- Arithmetic is unsigned and wraps modulo 2^SUM_W; there is no saturation.
- `prev_row` is never cleared. Row 0 forces the previous-row term to zero, so stale buffer contents are harmless.
- Counters: `x` runs 0..width-1 and `y` runs 0..height-1. `x` wraps to 0 and `y` increments when a pixel is accepted at `x==width-1`.
- `wr_addr` increments by 1 per write, starting at 0.
- FSM states:
  - IDLE:
    - `pix_ready=0`, `busy=0`.
    - On `start`, latch `width` and `height`, then check them.
    - If `width==0`, `height==0`, `width>MAX_WIDTH`, or `width*height > 2^ADDR_W`, go to REJECT.
    - Otherwise clear `x`, `y`, `row_sum` and `wr_addr`, then go to RUN.
  - RUN:
    - `pix_ready=1`, `busy=1`.
    - A pixel is accepted when `pix_valid & pix_ready`.
    - Accepting pixel (width-1, height-1) moves the FSM to LAST.
  - LAST:
    - `pix_ready=0`, `busy=1`.
    - The final write is on the bus this cycle and `done=1`.
    - Next state is IDLE.
  - REJECT:
    - `err=1` and `done=1` for one cycle.
    - No writes occur. Next state is IDLE.
- `start` outside IDLE is ignored.
- `pix_valid` outside RUN is ignored; no acceptance takes place.

## Timing
- Reset values (`reset==0` at a clock edge):
  - FSM goes to IDLE.
  - `pix_ready`, `wr_en`, `busy`, `done` and `err` are 0.
  - `wr_addr`, `wr_data`, `x`, `y` and `row_sum` are 0.
- Reset mid-frame aborts the frame immediately and produces no `done`. Writes already issued stand.
- `start` is sampled in cycle T.
  - Valid dimensions: `busy` and `pix_ready` are 1 from T+1.
  - Rejected dimensions: `err` and `done` pulse in T+1.
- Write latency: a pixel accepted at edge T gives `wr_en=1` with its `wr_addr` and `wr_data` during cycle T+1.
- Throughput is one pixel per cycle with no bubbles at row boundaries.
- `wr_en` is 0 in any cycle that follows a non-accept.
- `done` pulses in the same cycle as the last `wr_en`; `busy` drops the cycle after.
- Back-to-back frames: `start` may be asserted in the `done` cycle, but it is sampled only after the FSM returns to IDLE.
- The memory consumer must accept one write per cycle; there is no write backpressure.

## Test plan
- 3x3 frame, all pixels 1, `pix_valid` held high:
  - Writes addresses 0..8 with data 1,2,3,2,4,6,3,6,9 on consecutive cycles.
  - `done` is 1 alongside data 9.
- Same 3x3 frame with `pix_valid` toggling 1,0,1,0:
  - Identical address/data sequence.
  - `wr_en` is 1 only in the cycle after each accept.
- 4x2 frame, all pixels 255: last write is address 7, data 2040. Row 1 data is 510,1020,1530,2040.
- `width=0, height=5` with `start`:
  - `err` and `done` pulse in the next cycle.
  - No `wr_en`; `busy` stays 0.
- Reset low mid-row of a 4x4 frame, then a fresh 2x2 frame with pixels 1,2,3,4:
  - Writes 1,3,4,10 at addresses 0..3.
  - No `done` is produced from the aborted frame.
- `start` pulsed while RUN is active: the frame is unaffected and no second frame begins after `done`.
